// File: rtl/seq_alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_alu_pkg;

    // Same 3-bit opcode map as the older combinational 4-bit ALU.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_DIV = 3'b010,
        OP_MUL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_NOT = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// Latency: WIDTH cycles after start; done is high during the cycle of the final step.
// Backpressure: none; the caller must hold off start until done.
//
// Ports: start loads a/b/is_div and begins iterating; done flags the cycle whose
// step is the last one; lo/hi are the values the working register takes at the
// end of the current step (product low/high or quotient/remainder), so a
// consumer latching them on the done edge gets the final answer.
module seq_alu_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]        cnt;
    logic                 div_mode;
    logic [WIDTH-1:0]     opnd;      // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0]   pr;        // {acc, multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0]   pr_nxt;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;

    always_comb begin
        // MUL: add multiplicand into the high half when the current LSB is set,
        // then shift the whole register right, keeping the carry.
        mul_sum   = {1'b0, pr[2*WIDTH-1:WIDTH]} + (pr[0] ? {1'b0, opnd} : '0);
        // DIV: shift next dividend bit into the partial remainder and try a subtract.
        div_shift = {pr[2*WIDTH-1:WIDTH], pr[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (div_mode) begin
            // The restored difference is always < divisor, so WIDTH bits suffice.
            pr_nxt = {(div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0]),
                      pr[WIDTH-2:0], div_ge};
        end else begin
            pr_nxt = {mul_sum, pr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_mode <= 1'b0;
            opnd     <= '0;
            pr       <= '0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            div_mode <= is_div;
            opnd     <= b;
            pr       <= {{WIDTH{1'b0}}, a};
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            pr  <= pr_nxt;
        end
    end

    assign done = (cnt == CW'(1));
    assign lo   = pr_nxt[WIDTH-1:0];
    assign hi   = pr_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: ADD/SUB/logic in one cycle, MUL/DIV iterate over WIDTH cycles.
// Latency: 1 cycle (single-cycle ops, DIV by zero), WIDTH+1 cycles to out_valid for MUL/DIV.
// Backpressure: result held with flags until out_ready; in_ready low until then.
//
// Ports: in_valid/in_ready accept opcode, operand_a, operand_b; out_valid/out_ready
// present result, remainder and flag_zero/carry/ovf/dz. clk rising edge, rst_n async low.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_dz
);

    localparam int MSB = WIDTH - 1;

    state_e           state;
    logic             op_div;
    logic             accept;
    logic             multi;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_rem;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_dz;

    assign accept = in_valid && in_ready;
    // DIV by zero short-circuits to the single-cycle path.
    assign multi  = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand_b != '0));

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && multi),
        .is_div (opcode == OP_DIV),
        .a      (operand_a),
        .b      (operand_b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_comb begin
        add_full  = {1'b0, operand_a} + {1'b0, operand_b};
        sub_full  = {1'b0, operand_a} - {1'b0, operand_b};
        sc_result = '0;
        sc_rem    = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sc_dz     = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_result = add_full[MSB:0];
                sc_carry  = add_full[WIDTH];
                sc_ovf    = (operand_a[MSB] == operand_b[MSB]) && (add_full[MSB] != operand_a[MSB]);
            end
            OP_SUB: begin
                sc_result = sub_full[MSB:0];
                sc_carry  = sub_full[WIDTH];   // borrow: a < b unsigned
                sc_ovf    = (operand_a[MSB] != operand_b[MSB]) && (sub_full[MSB] != operand_a[MSB]);
            end
            OP_DIV: begin
                // Only reaches the register path when operand_b is zero.
                sc_result = '1;
                sc_rem    = operand_a;
                sc_dz     = 1'b1;
            end
            OP_MUL: ;
            OP_AND: sc_result = operand_a & operand_b;
            OP_OR:  sc_result = operand_a | operand_b;
            OP_NOT: sc_result = ~operand_a;
            OP_XOR: sc_result = operand_a ^ operand_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_div     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            remainder  <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_div   <= (opcode == OP_DIV);
                        in_ready <= 1'b0;
                        if (multi) begin
                            state <= ST_BUSY;
                        end else begin
                            state      <= ST_DONE;
                            out_valid  <= 1'b1;
                            result     <= sc_result;
                            remainder  <= sc_rem;
                            flag_zero  <= (sc_result == '0);
                            flag_carry <= sc_carry;
                            flag_ovf   <= sc_ovf;
                            flag_dz    <= sc_dz;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        result     <= md_lo;
                        remainder  <= op_div ? md_hi : '0;
                        flag_zero  <= (md_lo == '0);
                        flag_carry <= 1'b0;
                        flag_ovf   <= !op_div && (md_hi != '0);
                        flag_dz    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
